// File: rtl/sprite_image_writer.sv
// Streams 8-bit palette-index pixels into a sprite RAM write port in raster order (addr = col + row*WIDTH).
// Optional macro SPRITE_WR_VBLANK_GATE_EN: accept pixels only while vblank is high.
module sprite_image_writer #(
  parameter int WIDTH  = 150,
  parameter int HEIGHT = 150,
  parameter int ADDR_W = 17
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              vblank,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept;
  logic at_end;
  logic term;

`ifdef SPRITE_WR_VBLANK_GATE_EN
  assign s_ready = (state_q == LOAD) & vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign s_ready = (state_q == LOAD);
`endif

  assign accept = s_valid & s_ready;
  assign at_end = (addr_q == LAST_ADDR);
  assign term   = accept & (s_last | at_end);

  // col/row track raster position; the address runs alongside as a plain counter
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = s_data;
          if (term) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = s_last ^ at_end;
          end else begin
            addr_d = addr_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == LOAD);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sprite_image_writer.sv
// Testbench for sprite_image_writer (WIDTH=4, HEIGHT=3): fixed table, corner sequences, randomized loads vs a transaction model.
module tb_sprite_image_writer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, vblank, s_valid, s_last;
  logic [7:0]    s_data;
  logic          s_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  sprite_image_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .pixel_clk(clk), .reset_n(reset_n), .start(start), .vblank(vblank),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // transaction-level model: pixel index within the image, not col/row
  logic          m_loading = 1'b0;
  int            m_idx = 0;
  logic          m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;
  logic [29:0]   e_vec;

  function automatic logic [29:0] pack(input logic rdy, input logic en, input logic [AW-1:0] a,
                                       input logic [7:0] d, input logic bsy, input logic dn, input logic er);
    return {rdy, en, a, d, bsy, dn, er};
  endfunction

  function automatic logic gate(input logic vb);
`ifdef SPRITE_WR_VBLANK_GATE_EN
    return vb;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string nm, input logic [29:0] expv);
    logic [29:0] got;
    got = {s_ready, wr_en, wr_addr, wr_data, busy, done, err};
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s vec %0d: got {rdy,en,addr,data,busy,done,err}=%h required %h (t=%0t)",
               nm, vectors, got, expv, $time);
    end
  endtask

  task automatic apply(input logic st, input logic v, input logic [7:0] d, input logic l, input logic vb);
    logic acc, trm;
    start = st; s_valid = v; s_data = d; s_last = l; vblank = vb;
    acc = m_loading && v && gate(vb);
    trm = acc && (l || m_idx == N - 1);
    if (!m_loading && st) begin
      m_loading = 1'b1; m_idx = 0; m_err = 1'b0;
    end else if (acc) begin
      m_addr = AW'(m_idx); m_data = d;
      if (trm) begin
        m_loading = 1'b0;
        m_err = (l != (m_idx == N - 1));
      end else m_idx++;
    end
    @(posedge clk); #1;
    e_vec = pack(m_loading & gate(vb), acc, m_addr, m_data, m_loading, trm, m_err);
  endtask

  task automatic step(input string nm, input logic st, input logic v, input logic [7:0] d,
                      input logic l, input logic vb);
    apply(st, v, d, l, vb);
    check(nm, e_vec);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    m_loading = 1'b0; m_idx = 0; m_err = 1'b0; m_addr = '0; m_data = '0;
    check("reset_async", pack(0, 0, '0, '0, 0, 0, 0));
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic        st, v;
    logic [7:0]  d;
    logic        l;
    logic [29:0] expv;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0].st = 1'b1; tbl[0].v = 1'b0; tbl[0].d = 8'h00; tbl[0].l = 1'b0;
    tbl[0].expv = pack(1, 0, '0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tbl[i+1].st = 1'b0; tbl[i+1].v = 1'b1; tbl[i+1].d = 8'(8'h10 + i); tbl[i+1].l = (i == 11);
      tbl[i+1].expv = pack(i != 11, 1, AW'(i), 8'(8'h10 + i), i != 11, i == 11, 0);
    end
    tbl[13].st = 1'b0; tbl[13].v = 1'b0; tbl[13].d = 8'h00; tbl[13].l = 1'b0;
    tbl[13].expv = pack(0, 0, AW'(11), 8'h1B, 0, 0, 0);

    reset_n = 1'b0; start = 0; vblank = 1; s_valid = 0; s_data = 0; s_last = 0;
    #3 check("reset_state", pack(0, 0, '0, '0, 0, 0, 0));
    #5 reset_n = 1'b1;

    // 1: nominal 12-pixel load from the fixed table
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l, 1'b1);
      check("table", tbl[i].expv);
    end

    // 2: gappy s_valid
    step("gap_start", 1, 0, 0, 0, 1);
    for (int k = 0; k < 100 && m_loading; k++)
      step("gap", 0, ($urandom_range(0, 1) == 1), 8'($urandom), (m_idx == N - 1), 1);

    // 3: early s_last on pixel 5, then restart clears err
    step("early_start", 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step("early", 0, 1, 8'(8'h40 + i), (i == 5), 1);
    step("early_idle", 0, 1, 8'hEE, 0, 1);
    step("err_clear", 1, 0, 0, 0, 1);
    for (int k = 0; k < 40 && m_loading; k++) step("reload", 0, 1, 8'($urandom), (m_idx == N - 1), 1);

    // 4: no s_last; surplus pixels must be refused
    step("nolast_start", 1, 0, 0, 0, 1);
    for (int i = 0; i < N + 3; i++) step("nolast", 0, 1, 8'(8'h60 + i), 0, 1);

    // 5: reset after pixel 7 accepted, then a clean reload
    step("rst_start", 1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("rst_load", 0, 1, 8'(8'h80 + i), 0, 1);
    pulse_reset();
    step("rst_restart", 1, 0, 0, 0, 1);
    for (int k = 0; k < 40 && m_loading; k++) step("rst_reload", 0, 1, 8'($urandom), (m_idx == N - 1), 1);

    // 6: vblank low for 20 cycles mid-load
    step("vb_start", 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("vb_pre", 0, 1, 8'(8'hA0 + i), 0, 1);
    for (int i = 0; i < 20; i++) step("vb_low", 0, 1, 8'($urandom), (m_idx == N - 1), 0);
    for (int k = 0; k < 40 && m_loading; k++) step("vb_high", 0, 1, 8'($urandom), (m_idx == N - 1), 1);

    // randomized loads, including stray start pulses mid-load
    for (int ld = 0; ld < 8; ld++) begin
      step("rnd_start", 1, 0, 0, 0, 1);
      for (int k = 0; k < 200 && m_loading; k++)
        step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0));
      for (int k = 0; k < 3; k++) step("rnd_idle", 0, $urandom_range(0, 1) == 1, 8'($urandom), 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
